// File: rtl/bomberman_tile_pkg.sv
// Shared definitions for the Bomberman tile renderer: tile types, palette,
// grid geometry and the default arena layout.
package bomberman_tile_pkg;

    localparam int TILE_COLS      = 20;
    localparam int TILE_ROWS      = 15;
    localparam int TILE_SHIFT     = 5;
    localparam int TILE_RAM_DEPTH = TILE_COLS * TILE_ROWS;
    localparam int TILE_ADDR_W    = 9;

    typedef enum logic [2:0] {
        TILE_EMPTY   = 3'd0,
        TILE_HARD    = 3'd1,
        TILE_SOFT    = 3'd2,
        TILE_BOMB    = 3'd3,
        TILE_FLAME   = 3'd4,
        TILE_POWERUP = 3'd5,
        TILE_RSVD6   = 3'd6,
        TILE_RSVD7   = 3'd7
    } tile_t;

    localparam logic [11:0] COLOR_BLACK     = 12'h000;
    localparam logic [11:0] COLOR_GRASS     = 12'h0A0;
    localparam logic [11:0] COLOR_GRID      = 12'h060;
    localparam logic [11:0] COLOR_HARD_EDGE = 12'h444;
    localparam logic [11:0] COLOR_HARD_FACE = 12'h888;
    localparam logic [11:0] COLOR_MORTAR    = 12'hCCC;
    localparam logic [11:0] COLOR_BRICK     = 12'hA52;
    localparam logic [11:0] COLOR_FLAME     = 12'hF80;
    localparam logic [11:0] COLOR_POWERUP   = 12'h0AF;
    localparam logic [11:0] COLOR_RESERVED  = 12'hF0F;

    // Default arena: solid border plus a pillar on every even/even tile.
    function automatic logic [2:0] arena_tile(input logic [4:0] col, input logic [3:0] row);
        logic hard;
        hard = (row == 4'd0) || (32'(row) == TILE_ROWS - 1) ||
               (col == 5'd0) || (32'(col) == TILE_COLS - 1) ||
               (!row[0] && !col[0]);
        return hard ? TILE_HARD : TILE_EMPTY;
    endfunction

endpackage

// File: rtl/bomberman_tile_ram.sv
// Tile-type RAM: one write port, one registered read port, read-first so a
// same-cycle write and read of one address returns the previous contents.
module tile_ram #(
    parameter int DEPTH = 300,
    parameter int AW    = 9,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Write port; contents are not reset, the fill FSM initialises them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sees the value stored before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/bomberman_tile_renderer.sv
// Bomberman tile renderer: 3-stage scan pipeline (position -> tile RAM read ->
// palette) feeding the VGA timing stage, plus an arena fill FSM and a game
// write port into the tile RAM.
// Optional feature: define TILE_GRID_LINES_EN to draw 1-px grid lines on the
// left/top edge of EMPTY tiles and the background of BOMB tiles.
module bomberman_tile_renderer
    import bomberman_tile_pkg::*;
#(
    parameter int TILE_COLS  = bomberman_tile_pkg::TILE_COLS,
    parameter int TILE_ROWS  = bomberman_tile_pkg::TILE_ROWS,
    parameter int TILE_SHIFT = bomberman_tile_pkg::TILE_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        video_on,
    input  logic        wr_en,
    input  logic [4:0]  wr_col,
    input  logic [3:0]  wr_row,
    input  logic [2:0]  wr_tile,
    input  logic        clear_req,
    output logic        busy,
    output logic        init_done,
    output logic [11:0] color
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam int SCREEN_W = TILE_COLS << TILE_SHIFT;
    localparam int SCREEN_H = TILE_ROWS << TILE_SHIFT;

    // Fill FSM state
    logic [0:0]             r_state;
    logic                   r_start_pend;
    logic                   r_init_done;
    logic [4:0]             r_fill_col;
    logic [3:0]             r_fill_row;
    logic [TILE_ADDR_W-1:0] r_fill_addr;

    // Pipeline registers
    logic [4:0]  r_col1;
    logic [4:0]  r_row1;
    logic [4:0]  r_lx1;
    logic [4:0]  r_ly1;
    logic        r_vis1;
    logic [4:0]  r_lx2;
    logic [4:0]  r_ly2;
    logic        r_vis2;
    logic [11:0] r_color;

    // RAM ports
    logic                   w_wr_ok;
    logic [TILE_ADDR_W-1:0] w_port_addr;
    logic                   w_ram_we;
    logic [TILE_ADDR_W-1:0] w_ram_waddr;
    logic [2:0]             w_ram_wdata;
    logic [TILE_ADDR_W-1:0] w_rd_addr;
    logic [2:0]             w_rd_tile;
    logic                   w_vis0;
    logic                   w_grid;
    logic [11:0]            w_pix;

    assign busy      = (r_state == ST_FILL);
    assign init_done = r_init_done;
    assign color     = r_color;

    // Game writes only land in a settled IDLE, in range, and never alongside
    // a clear request (the clear wins). The pending start-up fill also blocks them.
    assign w_port_addr = TILE_ADDR_W'(32'(wr_row) * TILE_COLS + 32'(wr_col));
    assign w_wr_ok     = (r_state == ST_IDLE) && !r_start_pend && !clear_req && wr_en &&
                         (32'(wr_col) < TILE_COLS) && (32'(wr_row) < TILE_ROWS);

    assign w_ram_we    = busy ? 1'b1 : w_wr_ok;
    assign w_ram_waddr = busy ? r_fill_addr : w_port_addr;
    assign w_ram_wdata = busy ? arena_tile(r_fill_col, r_fill_row) : wr_tile;

    // Off-screen positions can overflow the RAM, so they read entry 0 instead.
    assign w_rd_addr = r_vis1 ? TILE_ADDR_W'(32'(r_row1) * TILE_COLS + 32'(r_col1)) : '0;

    assign w_vis0 = video_on && (32'(x_pos) < SCREEN_W) && (32'(y_pos) < SCREEN_H);

    tile_ram #(
        .DEPTH (TILE_RAM_DEPTH),
        .AW    (TILE_ADDR_W),
        .DW    (3)
    ) u_tile_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_ram_we),
        .wr_addr (w_ram_waddr),
        .wr_data (w_ram_wdata),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_tile)
    );

    // Fill FSM: one arena entry per cycle, column fastest, start-up fill after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_pend <= 1'b1;
            r_init_done  <= 1'b0;
            r_fill_col   <= '0;
            r_fill_row   <= '0;
            r_fill_addr  <= '0;
        end else begin
            r_init_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_start_pend || clear_req) begin
                        r_state      <= ST_FILL;
                        r_start_pend <= 1'b0;
                        r_fill_col   <= '0;
                        r_fill_row   <= '0;
                        r_fill_addr  <= '0;
                    end
                end
                default: begin
                    if ((32'(r_fill_col) == TILE_COLS - 1) && (32'(r_fill_row) == TILE_ROWS - 1)) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        if (32'(r_fill_col) == TILE_COLS - 1) begin
                            r_fill_col <= '0;
                            r_fill_row <= r_fill_row + 4'd1;
                        end else begin
                            r_fill_col <= r_fill_col + 5'd1;
                        end
                        r_fill_addr <= r_fill_addr + 1'b1;
                    end
                end
            endcase
        end
    end

    // S1: split scan position into tile index and in-tile offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col1 <= '0;
            r_row1 <= '0;
            r_lx1  <= '0;
            r_ly1  <= '0;
            r_vis1 <= 1'b0;
        end else begin
            r_col1 <= 5'(x_pos >> TILE_SHIFT);
            r_row1 <= 5'(y_pos >> TILE_SHIFT);
            r_lx1  <= x_pos[4:0];
            r_ly1  <= y_pos[4:0];
            r_vis1 <= w_vis0;
        end
    end

    // S2: offsets and visibility travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lx2  <= '0;
            r_ly2  <= '0;
            r_vis2 <= 1'b0;
        end else begin
            r_lx2  <= r_lx1;
            r_ly2  <= r_ly1;
            r_vis2 <= r_vis1;
        end
    end

`ifdef TILE_GRID_LINES_EN
    assign w_grid = (r_lx2 == 5'd0) || (r_ly2 == 5'd0);
`else
    assign w_grid = 1'b0;
`endif

    // Palette: tile type plus in-tile offset to a 12-bit RGB pixel.
    always_comb begin
        w_pix = COLOR_BLACK;
        case (w_rd_tile)
            TILE_EMPTY: w_pix = w_grid ? COLOR_GRID : COLOR_GRASS;
            TILE_HARD: begin
                if (r_lx2 < 5'd2 || r_lx2 > 5'd29 || r_ly2 < 5'd2 || r_ly2 > 5'd29)
                    w_pix = COLOR_HARD_EDGE;
                else
                    w_pix = COLOR_HARD_FACE;
            end
            TILE_SOFT: begin
                if ((r_ly2[2:0] == 3'd0) ||
                    (r_lx2[3:0] == 4'd0 && !r_ly2[3]) ||
                    (r_lx2[3:0] == 4'd8 &&  r_ly2[3]))
                    w_pix = COLOR_MORTAR;
                else
                    w_pix = COLOR_BRICK;
            end
            TILE_BOMB: begin
                if (r_lx2 >= 5'd8 && r_lx2 <= 5'd23 && r_ly2 >= 5'd8 && r_ly2 <= 5'd23)
                    w_pix = COLOR_BLACK;
                else
                    w_pix = w_grid ? COLOR_GRID : COLOR_GRASS;
            end
            TILE_FLAME:   w_pix = COLOR_FLAME;
            TILE_POWERUP: w_pix = COLOR_POWERUP;
            default:      w_pix = COLOR_RESERVED;
        endcase
    end

    // S3: register the pixel, blanked outside active video and during a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_color <= '0;
        end else begin
            r_color <= (r_vis2 && !busy) ? w_pix : COLOR_BLACK;
        end
    end

endmodule

// File: tb/tb_bomberman_tile_renderer.sv
// Directed bench for bomberman_tile_renderer: expected pixels are queued as
// each probe is driven and compared when the 3-stage pipeline delivers them.
module tb_bomberman_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        video_on;
    logic        wr_en;
    logic [4:0]  wr_col;
    logic [3:0]  wr_row;
    logic [2:0]  wr_tile;
    logic        clear_req;
    logic        busy;
    logic        init_done;
    logic [11:0] color;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q [$];
    string       tag_q [$];

    bomberman_tile_renderer dut (
        .clk       (clk),
        .rst       (rst),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .video_on  (video_on),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_tile   (wr_tile),
        .clear_req (clear_req),
        .busy      (busy),
        .init_done (init_done),
        .color     (color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a scan position, queue its expected colour, compare 3 clocks later.
    task automatic probe(input string tag, input int x, input int y, input logic vo,
                         input logic [11:0] exp);
        logic [11:0] e;
        string       t;
        x_pos    = 10'(x);
        y_pos    = 10'(y);
        video_on = vo;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(color), 32'(e));
        $display("probe %-14s x=%0d y=%0d vo=%0b color=%03h", t, x, y, vo, color);
    endtask

    task automatic write_tile(input int col, input int row, input logic [2:0] tile);
        wr_en   = 1'b1;
        wr_col  = 5'(col);
        wr_row  = 4'(row);
        wr_tile = tile;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        $display("write col=%0d row=%0d tile=%0d", col, row, tile);
    endtask

    // Follow one fill from its trigger edge. Optionally re-request a clear
    // mid-fill (clr_at) or abort the fill with reset (rst_at).
    task automatic measure_fill(input string tag, input int clr_at, input int rst_at);
        int   busy_cnt;
        int   done_cnt;
        logic seen;
        logic finished;
        busy_cnt = 0;
        done_cnt = 0;
        seen     = 1'b0;
        finished = 1'b0;
        x_pos    = 10'd40;
        y_pos    = 10'd40;
        video_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            clear_req = 1'b0;
            wr_en     = 1'b0;
            if (i == 0) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (busy) begin
                busy_cnt++;
                seen = 1'b1;
            end
            if (init_done) begin
                done_cnt++;
                check({tag, "_done_busy"}, 32'(busy), 32'd0);
            end
            if (busy && busy_cnt == 50) check({tag, "_blank_busy"}, 32'(color), 32'h000);
            if (busy && busy_cnt == 60) begin
                wr_en   = 1'b1;
                wr_col  = 5'd3;
                wr_row  = 4'd1;
                wr_tile = 3'd3;
            end
            if (busy && busy_cnt == clr_at) clear_req = 1'b1;
            if (busy && busy_cnt == rst_at) begin
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_color"}, 32'(color), 32'h000);
                $display("fill %s aborted by reset after %0d busy cycles", tag, busy_cnt);
                rst = 1'b0;
                return;
            end
            if (seen && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'd300);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        $display("fill %s busy=%0d cycles init_done pulses=%0d", tag, busy_cnt, done_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        x_pos     = '0;
        y_pos     = '0;
        video_on  = 1'b0;
        wr_en     = 1'b0;
        wr_col    = '0;
        wr_row    = '0;
        wr_tile   = '0;
        clear_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_color", 32'(color), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        $display("reset color=%03h busy=%0b init_done=%0b", color, busy, init_done);

        // Start-up fill
        rst = 1'b0;
        measure_fill("init", -1, -1);

        // Default arena readback
        probe("hard_11",  16, 16, 1'b1, 12'h888);
        probe("empty_11", 48, 48, 1'b1, 12'h0A0);
        probe("hard_22",  80, 80, 1'b1, 12'h888);
        probe("hard_edge0", 0, 16, 1'b1, 12'h444);
        probe("hard_edge31", 31, 16, 1'b1, 12'h444);
`ifdef TILE_GRID_LINES_EN
        probe("grid_line", 32, 40, 1'b1, 12'h060);
`else
        probe("no_grid",   32, 40, 1'b1, 12'h0A0);
`endif
        probe("grid_off", 33, 40, 1'b1, 12'h0A0);

        // Soft block brick pattern
        write_tile(1, 1, 3'd2);
        probe("soft_mortar", 32, 33, 1'b1, 12'hCCC);
        probe("soft_brick",  33, 35, 1'b1, 12'hA52);

        // Remaining tile types
        write_tile(3, 1, 3'd3);
        probe("bomb_body", 112, 48, 1'b1, 12'h000);
        probe("bomb_bg",    98, 34, 1'b1, 12'h0A0);
        write_tile(5, 1, 3'd4);
        probe("flame",     176, 48, 1'b1, 12'hF80);
        write_tile(7, 1, 3'd5);
        probe("powerup",   240, 48, 1'b1, 12'h0AF);
        write_tile(9, 1, 3'd6);
        probe("reserved",  304, 48, 1'b1, 12'hF0F);

        // Out-of-range column must not wrap onto tile (0,1)
        write_tile(20, 0, 3'd0);
        probe("oob_col", 16, 48, 1'b1, 12'h888);

        // Blanking
        probe("video_off", 16, 16, 1'b0, 12'h000);
        probe("x_700",    700, 16, 1'b1, 12'h000);
        probe("y_480",     16, 480, 1'b1, 12'h000);

        // Clear and write together: clear wins; a second clear mid-fill is ignored
        clear_req = 1'b1;
        wr_en     = 1'b1;
        wr_col    = 5'd3;
        wr_row    = 4'd1;
        wr_tile   = 3'd3;
        measure_fill("clear", 100, -1);
        probe("clr_bomb_gone",  112, 48, 1'b1, 12'h0A0);
        probe("clr_soft_gone",   40, 40, 1'b1, 12'h0A0);
        probe("clr_flame_gone", 176, 48, 1'b1, 12'h0A0);

        // Reset mid-fill, then a full refill
        clear_req = 1'b1;
        measure_fill("abort", -1, 150);
        measure_fill("refill", -1, -1);
        probe("refill_hard", 16, 16, 1'b1, 12'h888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
